nor_gate_checker: RTL
=====================

# nor_gate_checker

Self-checking exhaustive tester for a two-input NOR cell (transistor-level or RTL model). On a start request it drives the four input vectors onto the cell's A and B inputs in the same order as the lab stimulus (B toggles fastest). After a programmable settle time it samples the cell's Y output and compares it with the NOR truth table. It counts mismatches and reports pass/fail, so the cell experiments can be graded without reading waveforms.

## Interface
- DWELL, 4: clock cycles each input vector is held; legal range ≥2.
- SETTLE, 2: cycles after a vector change before Y is sampled; legal range 1..DWELL-1.
- ERRW, 8: width of the mismatch counter.
- CLK  in  1  single clock, rising-edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  run request, level-sampled.
- Y  in  1  output of the cell under test.
- A  out  1  cell input A; registered.
- B  out  1  cell input B; registered.
- BUSY  out  1  run in progress.
- DONE  out  1  run finished; level.
- PASS  out  1  DONE and zero mismatches.
- ERR_CNT  out  ERRW  mismatch count, saturating.
- FAIL_VLD  out  1  at least one mismatch recorded.
- FAIL_VEC  out  2  {A,B} of the first mismatching vector.

## Operation
- Clock and reset: one clock, CLK. RST_N is asynchronous and active-low.
- Reset values: state IDLE, and all outputs 0 (A, B, BUSY, DONE, PASS, ERR_CNT, FAIL_VLD, FAIL_VEC).
- States:
  - IDLE: START=1 → RUN.
  - RUN: steps through the four vectors. After the last dwell cycle of vector 3 → DONE.
  - DONE: START=1 → RUN; otherwise stays in DONE.
- START is ignored in RUN. START may be held high; each new run begins only from IDLE or DONE.
- On entry to RUN:
  - vector index v=0, dwell counter d=0.
  - ERR_CNT, FAIL_VLD, FAIL_VEC, DONE and PASS cleared.
  - BUSY=1.
- Drive: {A,B} = v. Vector order is 00, 01, 10, 11.
- Dwell: d counts 0..DWELL-1. When d=DWELL-1, d wraps to 0 and v increments. When v=3 and d=DWELL-1, the next state is DONE.
- Compare:
  - In the cycle with d=SETTLE, the sampling edge compares Y with ~(A|B).
  - Any non-match counts as a mismatch, including X or Z (case inequality in simulation).
  - On a mismatch: ERR_CNT increments and saturates at 2^ERRW-1. If FAIL_VLD=0, FAIL_VEC←v and FAIL_VLD←1.
- Outputs in DONE: BUSY=0, DONE=1, PASS = (ERR_CNT==0).
- A and B keep their last driven values in DONE (11) until the next RUN re-drives 00. After reset they are 00.

## Timing
- START sampled high at edge E. At E: BUSY=1, {A,B}=00, d=0.
- Vector v is driven from edge E+v·DWELL to E+(v+1)·DWELL.
- Y for vector v is sampled at edge E+v·DWELL+SETTLE+1. A cell with register latency L≤SETTLE is therefore sampled correctly.
- At edge E+4·DWELL: BUSY=0, DONE=1, PASS valid. Total run length is 4·DWELL cycles.
- Back-to-back runs: if START is high in DONE, the next edge re-enters RUN. DONE drops and the counters clear on that same edge.
- Reset asserted mid-run: all outputs clear immediately, without waiting for a clock edge. After RST_N deasserts, the block waits in IDLE for a new START.
- Error saturation: while saturated, FAIL_VEC still tracks only the first failure.

## Test plan
All cases use DWELL=4, SETTLE=2 unless noted.

- **Ideal NOR model:** Y=~(A|B), START pulse. A/B go 00, 01, 10, 11, each held 4 cycles. BUSY is high for exactly 16 cycles, then DONE=1, PASS=1, ERR_CNT=0, FAIL_VLD=0.
- **Stuck-at-0 model:** Y=0. Result: ERR_CNT=1, FAIL_VEC=00, FAIL_VLD=1, PASS=0.
- **NAND model:** Y=~(A&B). Result: ERR_CNT=2, FAIL_VEC=01, PASS=0.
- **Delayed DUT:** NOR model behind a 2-register pipeline gives PASS=1. With a 3-register pipeline, START is issued ≥5 cycles after reset release: ERR_CNT=1, FAIL_VEC=01, PASS=0.
- **Saturation:** ERRW=2 with an OR model (4 mismatches). Result: ERR_CNT=3 (saturated), FAIL_VEC=00. A second START from DONE clears ERR_CNT to 0 on the entry edge and reruns with the same result.
- **Reset and START handling:**
  - START re-pulsed mid-run: no restart, BUSY still lasts 16 cycles.
  - RST_N low at cycle 7 of a run: all outputs 0 without waiting for a clock edge, state IDLE, and no DONE until a new START.

Source files
------------

// File: rtl/nor_gate_checker_if.sv
// Stimulus/response and status bundle between the NOR checker and its cell/host.
// master = checker side, slave = cell-under-test and host side.
interface nor_gate_checker_if #(
   parameter int ERRW = 8
);
   logic            start;
   logic            y;
   logic            a;
   logic            b;
   logic            busy;
   logic            done;
   logic            pass;
   logic [ERRW-1:0] err_cnt;
   logic            fail_vld;
   logic [1:0]      fail_vec;

   modport master (
      input  start, y,
      output a, b, busy, done, pass, err_cnt, fail_vld, fail_vec
   );

   modport slave (
      output start, y,
      input  a, b, busy, done, pass, err_cnt, fail_vld, fail_vec
   );
endinterface

// File: rtl/nor_gate_checker.sv
// Exhaustive 2-input NOR tester: 4 vectors x DWELL cycles, Y sampled at d==SETTLE.
// Run lasts 4*DWELL cycles; START is ignored while busy, no other backpressure.
module nor_gate_checker #(
   parameter int DWELL  = 4,
   parameter int SETTLE = 2,
   parameter int ERRW   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   nor_gate_checker_if.master bus
);
   localparam int DW = (DWELL > 2) ? $clog2(DWELL) : 1;
   localparam logic [DW-1:0] D_LAST = DW'(DWELL - 1);
   localparam logic [DW-1:0] D_SMP  = DW'(SETTLE);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]      state;
   logic [1:0]      vec;
   logic [DW-1:0]   d;
   logic            busy;
   logic            done;
   logic            pass;
   logic [ERRW-1:0] err_cnt;
   logic            fail_vld;
   logic [1:0]      fail_vec;

   logic            mism;
   logic [ERRW-1:0] err_nxt;

   // The vector register is the registered {A,B} drive; it holds 11 in DONE.
   assign bus.a        = vec[1];
   assign bus.b        = vec[0];
   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.pass     = pass;
   assign bus.err_cnt  = err_cnt;
   assign bus.fail_vld = fail_vld;
   assign bus.fail_vec = fail_vec;

   always_comb begin
      mism    = 1'b0;
      err_nxt = err_cnt;
      if (state == S_RUN && d == D_SMP)
         mism = (bus.y !== ~(vec[1] | vec[0]));
      if (mism && !(&err_cnt))
         err_nxt = err_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         vec      <= 2'b00;
         d        <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         err_cnt  <= '0;
         fail_vld <= 1'b0;
         fail_vec <= 2'b00;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  state    <= S_RUN;
                  vec      <= 2'b00;
                  d        <= '0;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  pass     <= 1'b0;
                  err_cnt  <= '0;
                  fail_vld <= 1'b0;
                  fail_vec <= 2'b00;
               end
            end
            S_RUN: begin
               err_cnt <= err_nxt;
               if (mism && !fail_vld) begin
                  fail_vld <= 1'b1;
                  fail_vec <= vec;
               end
               if (d == D_LAST) begin
                  d <= '0;
                  // err_nxt covers a compare that lands on the final dwell cycle.
                  if (vec == 2'b11) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (err_nxt == '0);
                  end else begin
                     vec <= vec + 2'b01;
                  end
               end else begin
                  d <= d + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
